memory_responder: RTL and testbench

Memory-side responder for the control unit's memory handshake. Accepts a request marked by `mov` (memory operation valid) together with `read_write`, `data_length`, address and write data from the MAR/MDR path. After a fixed latency it performs a big-endian byte, halfword or word access on an internal byte-addressed RAM and raises `moc` (memory operation complete). It sits between the datapath's MAR/MDR and the microsequencer, which waits on `moc` before advancing.

---
 rtl/memory_responder.sv | 142 ++++++++++++++
 tb/tb_memory_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Memory-side responder: captures a MAR/MDR request on mov, waits a fixed latency,
// performs a big-endian byte/halfword/word access on a local byte RAM and raises moc.
module memory_responder #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned LATENCY    = 2,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mov,
   input  logic        read_write,
   input  logic [1:0]  data_length,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        moc
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LANES = 4;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rw_q, rw_d;
   logic [1:0]            len_q, len_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  moc_q, moc_d;
   logic                  mem_we;

   logic [7:0]            mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] lane_addr [LANES];
   logic [7:0]            lane_byte [LANES];
   logic [31:0]           rd_result;

   logic                  unused_addr_hi;
   assign unused_addr_hi = ^address[31:ADDR_WIDTH];

   // Lane k is the byte at a+k, wrapping within the RAM
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_addr[k] = addr_q + ADDR_WIDTH'(k);
         lane_byte[k] = mem_q[lane_addr[k]];
      end
   end

   always_comb begin
      rd_result = 32'h0;
      case (len_q)
         2'b00:   rd_result = {24'h0, lane_byte[0]};
         2'b01:   rd_result = {16'h0, lane_byte[0], lane_byte[1]};
         default: rd_result = {lane_byte[0], lane_byte[1], lane_byte[2], lane_byte[3]};
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      len_d   = len_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      moc_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mov) begin
               addr_d  = address[ADDR_WIDTH-1:0];
               rw_d    = read_write;
               len_d   = data_length;
               wdata_d = data_in;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (rw_q) rdata_d = rd_result;
               else      mem_we  = 1'b1;
               moc_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (mov) moc_d   = 1'b1;
            else     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         len_q   <= 2'b00;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         moc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         len_q   <= len_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         moc_q   <= moc_d;
      end
   end

   // RAM keeps its contents across reset; the MSB of the transfer lands at a
   always_ff @(posedge clk) begin
      if (mem_we) begin
         case (len_q)
            2'b00: mem_q[lane_addr[0]] <= wdata_q[7:0];
            2'b01: begin
               mem_q[lane_addr[0]] <= wdata_q[15:8];
               mem_q[lane_addr[1]] <= wdata_q[7:0];
            end
            default: begin
               mem_q[lane_addr[0]] <= wdata_q[31:24];
               mem_q[lane_addr[1]] <= wdata_q[23:16];
               mem_q[lane_addr[2]] <= wdata_q[15:8];
               mem_q[lane_addr[3]] <= wdata_q[7:0];
            end
         endcase
      end
   end

   assign data_out = rdata_q;
   assign moc      = moc_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed handshake/lane cases plus random traffic
// checked against a byte-array model of the RAM.
module tb_memory_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset;
   logic        mov;
   logic        read_write;
   logic [1:0]  data_length;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        moc;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model [DEPTH];
   logic [31:0] last_read = 32'h0;

   memory_responder #(.ADDR_WIDTH(9), .LATENCY(LAT), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .mov(mov), .read_write(read_write),
      .data_length(data_length), .address(address), .data_in(data_in),
      .data_out(data_out), .moc(moc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] len);
      logic [31:0] r = 32'h0;
      for (int k = 0; k < nbytes(len); k++)
         r = (r << 8) | {24'h0, model[(int'(a[8:0]) + k) % DEPTH]};
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] wd);
      int n = nbytes(len);
      for (int k = 0; k < n; k++)
         model[(int'(a[8:0]) + k) % DEPTH] = 8'(wd >> (8 * (n - 1 - k)));
   endtask

   // One full handshake; hold = extra cycles mov stays high after moc, drop = release mov right after capture
   task automatic op(input bit rd, input logic [1:0] len, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input bit drop, input string tag);
      int  n = 0;
      bit  seen = 0;
      @(negedge clk);
      mov = 1'b1; read_write = rd; data_length = len; address = a; data_in = wd;
      @(posedge clk);
      #1;
      address = $urandom; data_in = $urandom; data_length = 2'($urandom); read_write = 1'($urandom);
      if (drop) begin
         @(negedge clk);
         mov = 1'b0;
      end
      while (!seen && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (moc === 1'b1) seen = 1;
      end
      chk({tag, " moc_seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(n), 32'(LAT));
      if (rd) last_read = model_read(a, len);
      else    model_write(a, len, wd);
      chk({tag, " data_out"}, data_out, last_read);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, " moc_held"}, 32'(moc), 32'd1);
      end
      @(negedge clk);
      mov = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " moc_fall"}, 32'(moc), 32'd0);
   endtask

   initial begin
      reset = 1'b0; mov = 1'b0; read_write = 1'b0; data_length = 2'b00;
      address = 32'h0; data_in = 32'h0;
      #12;
      chk("reset moc", 32'(moc), 32'd0);
      chk("reset data_out", data_out, 32'h0);
      #8 reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("idle moc", 32'(moc), 32'd0);
         chk("idle data_out", data_out, 32'h0);
      end

      for (int a = 0; a < DEPTH; a += 4)
         op(1'b0, 2'b10, 32'(a), $urandom, 0, 1'b0, "fill");

      op(1'b0, 2'b10, 32'h004, 32'hDEADBEEF, 0, 1'b0, "wr_word");
      op(1'b1, 2'b10, 32'h004, 32'h0, 0, 1'b0, "rd_word");
      chk("rd_word const", data_out, 32'hDEADBEEF);
      op(1'b1, 2'b00, 32'h004, 32'h0, 0, 1'b0, "rd_byte");
      chk("rd_byte const", data_out, 32'h000000DE);
      op(1'b1, 2'b01, 32'h006, 32'h0, 0, 1'b0, "rd_half");
      chk("rd_half const", data_out, 32'h0000BEEF);
      op(1'b0, 2'b00, 32'h005, 32'hFFFFFF55, 0, 1'b0, "wr_byte");
      op(1'b1, 2'b11, 32'h004, 32'h0, 0, 1'b0, "rd_merge");
      chk("rd_merge const", data_out, 32'hDE55BEEF);

      op(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h11223344, 0, 1'b0, "wr_wrap");
      op(1'b1, 2'b00, 32'h1FE, 32'h0, 0, 1'b0, "wrap0");
      chk("wrap0 const", data_out, 32'h11);
      op(1'b1, 2'b00, 32'h1FF, 32'h0, 0, 1'b0, "wrap1");
      chk("wrap1 const", data_out, 32'h22);
      op(1'b1, 2'b00, 32'h000, 32'h0, 0, 1'b0, "wrap2");
      chk("wrap2 const", data_out, 32'h33);
      op(1'b1, 2'b00, 32'h001, 32'h0, 0, 1'b0, "wrap3");
      chk("wrap3 const", data_out, 32'h44);

      op(1'b1, 2'b10, 32'h1FE, 32'h0, 5, 1'b0, "hold");
      op(1'b0, 2'b01, 32'h0A0, 32'h0000A5C3, 0, 1'b1, "drop");
      op(1'b1, 2'b01, 32'h0A0, 32'h0, 0, 1'b0, "drop_rd");
      chk("drop_rd const", data_out, 32'h0000A5C3);

      op(1'b0, 2'b10, 32'h010, 32'h0, 0, 1'b0, "abort_pre");
      @(negedge clk);
      mov = 1'b1; read_write = 1'b0; data_length = 2'b10; address = 32'h010; data_in = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; mov = 1'b0;
      #1;
      chk("abort data_out", data_out, 32'h0);
      last_read = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("abort moc", 32'(moc), 32'd0);
      end
      op(1'b1, 2'b10, 32'h010, 32'h0, 0, 1'b0, "abort_rd");
      chk("abort_rd const", data_out, 32'h0);

      for (int i = 0; i < 60; i++)
         op(1'($urandom), 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, "rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
